// File: rtl/rv32_mc_control.sv
// rv32_mc_control: multi-cycle RV32I control FSM with memory handshake, timeout watchdog and retire counter.
// Define CTRL_JALR_EN to decode JALR (op 1100111, funct3 000); otherwise it is treated as illegal.
module rv32_mc_control #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W = 8,
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic             fault,
    output logic [RET_W-1:0] retired
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_EXEC_JALR, S_ILLEGAL, S_FAULT
    } state_t;
    state_t state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic retire, to_hit;
    assign to_hit = TIMEOUT_CYCLES != 0 && int'(to_q) + 1 == TIMEOUT_CYCLES;
    assign illegal = !rst && state_q == S_ILLEGAL;
    assign fault = !rst && state_q == S_FAULT;
    assign retired = rst ? '0 : retired_q;
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we = 1'b0;
        adr_src = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        result_src = 2'b00;
        imm_src = 3'b000;
        alu_control = 4'b0000;
        retire = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alu_src_b = 2'b10;
                    result_src = 2'b10;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                    state_d = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src = 3'b010;
                    case (op)
                        7'b0000011, 7'b0100011: state_d = S_MEMADR;
                        7'b0110011: state_d = S_EXEC_R;
                        7'b0010011: state_d = S_EXEC_I;
                        7'b1100011: state_d = S_BRANCH;
                        7'b1101111: state_d = S_JAL;
`ifdef CTRL_JALR_EN
                        7'b1100111: state_d = funct3 == 3'b000 ? S_EXEC_JALR : S_ILLEGAL;
`endif
                        default: state_d = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src = op == 7'b0100011 ? 3'b001 : 3'b000;
                    state_d = op == 7'b0100011 ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    state_d = mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write = 1'b1;
                    retire = 1'b1;
                    state_d = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we = 1'b1;
                    adr_src = 1'b1;
                    retire = mem_ready;
                    state_d = mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_control = {funct7_5, funct3};
                    state_d = S_ALUWB;
                end
                // funct7_5 only distinguishes SRAI/SRLI among immediate ops
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_control = funct3 == 3'b101 ? {funct7_5, funct3} : {1'b0, funct3};
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire = 1'b1;
                    state_d = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_control = 4'b1000;
                    pc_write = funct3 == 3'b000 ? zero : funct3 == 3'b001 ? !zero : 1'b0;
                    retire = funct3[2:1] == 2'b00;
                    state_d = funct3[2:1] == 2'b00 ? S_FETCH : S_ILLEGAL;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write = 1'b1;
                    state_d = S_ALUWB;
                end
`ifdef CTRL_JALR_EN
                S_EXEC_JALR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    result_src = 2'b10;
                    pc_write = 1'b1;
                    state_d = S_JAL;
                end
`endif
                default: state_d = state_q;
            endcase
            if (mem_req && !mem_ready && to_hit) state_d = S_FAULT;
        end
        to_d = mem_req && !mem_ready ? to_q + 1'b1 : '0;
        retired_d = retired_q + RET_W'(retire);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            to_q <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            to_q <= to_d;
            retired_q <= retired_d;
        end
    end
endmodule
